// File: rtl/noc_flit_receiver.sv
// rtl/noc_flit_receiver.sv - NoC endpoint receiver: per-VC flit buffers, credit return, packet-locked round-robin output
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   flit_in           {valid, tail, dest, vc, data} from the upstream router
//   credit_out        {valid, vc}, one buffer slot freed, returned one cycle after a pop
//   recv_port_id      this endpoint's address, static after reset
//   out_valid/ready   handshake to the local consumer; pop = out_valid && out_ready
//   out_data/vc/tail  fields of the presented head flit
//   overflow_err      sticky: flit dropped (full VC or out-of-range vc)
//   misroute_err      sticky: flit dest did not match recv_port_id (flit still kept)
//   flit_count        (NOC_RECV_STATS_EN only) pops, wraps at 2^32
//   pkt_count         (NOC_RECV_STATS_EN only) tail pops, wraps at 2^32
//
// Build option: define NOC_RECV_STATS_EN to add flit_count/pkt_count.

module noc_flit_receiver #(
   parameter  int NUM_VCS         = 2,
   parameter  int FLIT_DATA_WIDTH = 32,
   parameter  int DEST_BITS       = 2,
   parameter  int BUFFER_DEPTH    = 4,
   localparam int VC_BITS         = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
   localparam int FW              = 2 + DEST_BITS + VC_BITS + FLIT_DATA_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [FW-1:0]              flit_in,
   output logic [VC_BITS:0]           credit_out,
   input  logic [DEST_BITS-1:0]       recv_port_id,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [FLIT_DATA_WIDTH-1:0] out_data,
   output logic [VC_BITS-1:0]         out_vc,
   output logic                       out_tail,
   output logic                       overflow_err,
   output logic                       misroute_err
`ifdef NOC_RECV_STATS_EN
   ,
   output logic [31:0]                flit_count,
   output logic [31:0]                pkt_count
`endif
);

   localparam int PTR_BITS = $clog2(BUFFER_DEPTH);
   localparam int CNT_BITS = $clog2(BUFFER_DEPTH + 1);

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

   logic                       in_valid;
   logic                       in_tail;
   logic [DEST_BITS-1:0]       in_dest;
   logic [VC_BITS-1:0]         in_vc;
   logic [FLIT_DATA_WIDTH-1:0] in_data;

   assign {in_valid, in_tail, in_dest, in_vc, in_data} = flit_in;

   // Each entry stores {tail, data}.
   logic [FLIT_DATA_WIDTH:0] mem    [NUM_VCS][BUFFER_DEPTH];
   logic [PTR_BITS-1:0]      wr_ptr [NUM_VCS];
   logic [PTR_BITS-1:0]      rd_ptr [NUM_VCS];
   logic [CNT_BITS-1:0]      count  [NUM_VCS];

   state_t               state;
   logic [VC_BITS-1:0]   lock_vc;
   logic [VC_BITS-1:0]   rr_ptr;
   logic [VC_BITS-1:0]   sel_vc;
   logic                 sel_found;
   logic                 pop;
   logic                 vc_ok;
   logic                 ovf_now;
   logic                 misroute_now;
   logic [NUM_VCS-1:0]   wr_en;
   logic [NUM_VCS-1:0]   pop_en;

   assign vc_ok        = 32'(in_vc) < NUM_VCS;
   assign misroute_now = in_valid && (in_dest != recv_port_id);

   // Head selection. In IDLE scan VCs starting at rr_ptr; in LOCKED only the
   // locked VC may be shown so a packet is never interleaved with another.
   always_comb begin
      logic [VC_BITS-1:0] cand;
      sel_found = 1'b0;
      sel_vc    = '0;
      cand      = '0;
      if (state == LOCKED) begin
         sel_vc    = lock_vc;
         sel_found = (count[lock_vc] != '0);
      end else begin
         for (int i = 0; i < NUM_VCS; i++) begin
            cand = VC_BITS'((int'(rr_ptr) + i) % NUM_VCS);
            if (!sel_found && count[cand] != '0) begin
               sel_found = 1'b1;
               sel_vc    = cand;
            end
         end
      end
   end

   assign out_valid           = sel_found;
   assign out_vc              = sel_vc;
   assign {out_tail, out_data} = mem[sel_vc][rd_ptr[sel_vc]];
   assign pop                 = sel_found && out_ready;

   // A full VC still accepts a write when it is popped in the same cycle.
   always_comb begin
      wr_en   = '0;
      pop_en  = '0;
      ovf_now = 1'b0;
      if (pop) pop_en[sel_vc] = 1'b1;
      if (in_valid && vc_ok) begin
         if (count[in_vc] != CNT_BITS'(BUFFER_DEPTH) || pop_en[in_vc])
            wr_en[in_vc] = 1'b1;
         else
            ovf_now = 1'b1;
      end else if (in_valid) begin
         ovf_now = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (|wr_en)
         mem[in_vc][wr_ptr[in_vc]] <= {in_tail, in_data};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int v = 0; v < NUM_VCS; v++) begin
            wr_ptr[v] <= '0;
            rd_ptr[v] <= '0;
            count[v]  <= '0;
         end
      end else begin
         for (int v = 0; v < NUM_VCS; v++) begin
            if (wr_en[v])  wr_ptr[v] <= wr_ptr[v] + PTR_BITS'(1);
            if (pop_en[v]) rd_ptr[v] <= rd_ptr[v] + PTR_BITS'(1);
            count[v] <= count[v] + CNT_BITS'(wr_en[v]) - CNT_BITS'(pop_en[v]);
         end
      end
   end

   // Selector FSM, credit return, error flags and statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         lock_vc      <= '0;
         rr_ptr       <= '0;
         credit_out   <= '0;
         overflow_err <= 1'b0;
         misroute_err <= 1'b0;
`ifdef NOC_RECV_STATS_EN
         flit_count   <= '0;
         pkt_count    <= '0;
`endif
      end else begin
         credit_out <= pop ? {1'b1, sel_vc} : '0;
         if (ovf_now)      overflow_err <= 1'b1;
         if (misroute_now) misroute_err <= 1'b1;
         if (pop) begin
            // Next arbitration starts just after the VC that was served.
            rr_ptr <= (sel_vc == VC_BITS'(NUM_VCS - 1)) ? '0 : sel_vc + VC_BITS'(1);
            if (out_tail) begin
               state <= IDLE;
            end else begin
               state   <= LOCKED;
               lock_vc <= sel_vc;
            end
`ifdef NOC_RECV_STATS_EN
            flit_count <= flit_count + 32'd1;
            if (out_tail) pkt_count <= pkt_count + 32'd1;
`endif
         end
      end
   end

endmodule

// File: tb/tb_noc_flit_receiver.sv
// tb/tb_noc_flit_receiver.sv - directed self-checking bench for noc_flit_receiver

module tb_noc_flit_receiver;

   logic        clk;
   logic        rst;
   logic [36:0] flit_in;
   logic [1:0]  credit_out;
   logic [1:0]  recv_port_id;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_vc;
   logic        out_tail;
   logic        overflow_err;
   logic        misroute_err;
`ifdef NOC_RECV_STATS_EN
   logic [31:0] flit_count;
   logic [31:0] pkt_count;
`endif

   int tests;
   int fails;

   noc_flit_receiver dut (
      .clk          (clk),
      .rst          (rst),
      .flit_in      (flit_in),
      .credit_out   (credit_out),
      .recv_port_id (recv_port_id),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_vc       (out_vc),
      .out_tail     (out_tail),
      .overflow_err (overflow_err),
      .misroute_err (misroute_err)
`ifdef NOC_RECV_STATS_EN
      ,
      .flit_count   (flit_count),
      .pkt_count    (pkt_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [36:0] mk(input logic t, input logic [1:0] d, input logic vc, input logic [31:0] data);
      return {1'b1, t, d, vc, data};
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1; flit_in = '0; out_ready = 1'b0;
      step; step;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      do_reset;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      tests++; if (credit_out !== 2'b00) begin fails++; $display("FAIL reset_credit got=%b want=00", credit_out); end
      tests++; if (overflow_err !== 1'b0) begin fails++; $display("FAIL reset_overflow got=%b want=0", overflow_err); end
      tests++; if (misroute_err !== 1'b0) begin fails++; $display("FAIL reset_misroute got=%b want=0", misroute_err); end
      tests++; if (dut.state !== 1'b0) begin fails++; $display("FAIL reset_state got=%b want=0", dut.state); end
`ifdef NOC_RECV_STATS_EN
      tests++; if (flit_count !== 32'd0) begin fails++; $display("FAIL reset_flit_count got=%0d want=0", flit_count); end
`endif
   endtask

   task automatic test_overflow;
      do_reset;
      recv_port_id = 2'd0;
      for (int i = 0; i < 4; i++) begin
         flit_in = mk(1'b1, 2'd0, 1'b0, 32'(10 + i));
         step;
         tests++; if (credit_out !== 2'b00) begin fails++; $display("FAIL ovf_fill_credit[%0d] got=%b want=00", i, credit_out); end
      end
      tests++; if (overflow_err !== 1'b0) begin fails++; $display("FAIL ovf_before got=%b want=0", overflow_err); end
      flit_in = mk(1'b1, 2'd0, 1'b0, 32'd99);
      step;
      flit_in = '0;
      tests++; if (overflow_err !== 1'b1) begin fails++; $display("FAIL ovf_flag got=%b want=1", overflow_err); end
      tests++; if (dut.count[0] !== 3'd4) begin fails++; $display("FAIL ovf_occupancy got=%0d want=4", dut.count[0]); end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL ovf_drain_valid[%0d] got=%b want=1", i, out_valid); end
         tests++; if (out_data !== 32'(10 + i)) begin fails++; $display("FAIL ovf_drain_data[%0d] got=%h want=%h", i, out_data, 32'(10 + i)); end
         step;
         tests++; if (credit_out !== 2'b10) begin fails++; $display("FAIL ovf_drain_credit[%0d] got=%b want=10", i, credit_out); end
      end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ovf_empty_valid got=%b want=0", out_valid); end
      step;
      tests++; if (credit_out !== 2'b00) begin fails++; $display("FAIL ovf_idle_credit got=%b want=00", credit_out); end
   endtask

   task automatic test_packet_order;
      do_reset;
      recv_port_id = 2'd0;
      out_ready = 1'b1;
      flit_in = mk(1'b0, 2'd0, 1'b0, 32'hbeef);
      step;
      tests++; if (out_valid !== 1'b1 || out_data !== 32'hbeef || out_vc !== 1'b0 || out_tail !== 1'b0) begin fails++; $display("FAIL pkt_head got=%b/%h/%b/%b want=1/beef/0/0", out_valid, out_data, out_vc, out_tail); end
      flit_in = mk(1'b1, 2'd0, 1'b1, 32'h1111);
      step;
      tests++; if (credit_out !== 2'b10) begin fails++; $display("FAIL pkt_credit_head got=%b want=10", credit_out); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL pkt_locked_valid got=%b want=0", out_valid); end
      flit_in = mk(1'b1, 2'd0, 1'b0, 32'h2222);
      step;
      flit_in = '0;
      tests++; if (credit_out !== 2'b00) begin fails++; $display("FAIL pkt_credit_gap got=%b want=00", credit_out); end
      tests++; if (out_valid !== 1'b1 || out_data !== 32'h2222 || out_vc !== 1'b0 || out_tail !== 1'b1) begin fails++; $display("FAIL pkt_tail got=%b/%h/%b/%b want=1/2222/0/1", out_valid, out_data, out_vc, out_tail); end
      step;
      tests++; if (credit_out !== 2'b10) begin fails++; $display("FAIL pkt_credit_tail got=%b want=10", credit_out); end
      tests++; if (out_valid !== 1'b1 || out_data !== 32'h1111 || out_vc !== 1'b1) begin fails++; $display("FAIL pkt_vc1 got=%b/%h/%b want=1/1111/1", out_valid, out_data, out_vc); end
      step;
      tests++; if (credit_out !== 2'b11) begin fails++; $display("FAIL pkt_credit_vc1 got=%b want=11", credit_out); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL pkt_empty got=%b want=0", out_valid); end
`ifdef NOC_RECV_STATS_EN
      tests++; if (flit_count !== 32'd3) begin fails++; $display("FAIL pkt_flit_count got=%0d want=3", flit_count); end
      tests++; if (pkt_count !== 32'd2) begin fails++; $display("FAIL pkt_pkt_count got=%0d want=2", pkt_count); end
`endif
      step;
      tests++; if (credit_out !== 2'b00) begin fails++; $display("FAIL pkt_credit_end got=%b want=00", credit_out); end
   endtask

   task automatic test_round_robin;
      logic [31:0] exp_d [4];
      exp_d[0] = 32'hA0; exp_d[1] = 32'hB0; exp_d[2] = 32'hA1; exp_d[3] = 32'hB1;
      do_reset;
      recv_port_id = 2'd0;
      for (int i = 0; i < 4; i++) begin
         flit_in = mk(1'b1, 2'd0, 1'(i % 2), exp_d[i]);
         step;
      end
      flit_in = '0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tests++; if (out_valid !== 1'b1 || out_vc !== 1'(i % 2) || out_data !== exp_d[i]) begin fails++; $display("FAIL rr_pop[%0d] got=%b/%b/%h want=1/%b/%h", i, out_valid, out_vc, out_data, 1'(i % 2), exp_d[i]); end
         step;
         tests++; if (credit_out !== {1'b1, 1'(i % 2)}) begin fails++; $display("FAIL rr_credit[%0d] got=%b want=%b", i, credit_out, {1'b1, 1'(i % 2)}); end
      end
      out_ready = 1'b0;
   endtask

   task automatic test_simultaneous;
      logic [31:0] exp_d [4];
      exp_d[0] = 32'd2; exp_d[1] = 32'd3; exp_d[2] = 32'd4; exp_d[3] = 32'h1234;
      do_reset;
      recv_port_id = 2'd0;
      for (int i = 1; i <= 4; i++) begin
         flit_in = mk(1'b1, 2'd0, 1'b0, 32'(i));
         step;
      end
      out_ready = 1'b1;
      flit_in = mk(1'b1, 2'd0, 1'b0, 32'h1234);
      step;
      flit_in = '0;
      out_ready = 1'b0;
      tests++; if (overflow_err !== 1'b0) begin fails++; $display("FAIL sim_overflow got=%b want=0", overflow_err); end
      tests++; if (dut.count[0] !== 3'd4) begin fails++; $display("FAIL sim_occupancy got=%0d want=4", dut.count[0]); end
      tests++; if (credit_out !== 2'b10) begin fails++; $display("FAIL sim_credit got=%b want=10", credit_out); end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tests++; if (out_valid !== 1'b1 || out_data !== exp_d[i]) begin fails++; $display("FAIL sim_drain[%0d] got=%b/%h want=1/%h", i, out_valid, out_data, exp_d[i]); end
         step;
      end
      out_ready = 1'b0;
   endtask

   task automatic test_misroute;
      do_reset;
      recv_port_id = 2'd1;
      step;
      tests++; if (misroute_err !== 1'b0) begin fails++; $display("FAIL mis_before got=%b want=0", misroute_err); end
      flit_in = mk(1'b1, 2'd2, 1'b1, 32'h55);
      step;
      flit_in = '0;
      tests++; if (misroute_err !== 1'b1) begin fails++; $display("FAIL mis_flag got=%b want=1", misroute_err); end
      tests++; if (overflow_err !== 1'b0) begin fails++; $display("FAIL mis_overflow got=%b want=0", overflow_err); end
      tests++; if (out_valid !== 1'b1 || out_data !== 32'h55 || out_vc !== 1'b1) begin fails++; $display("FAIL mis_delivered got=%b/%h/%b want=1/55/1", out_valid, out_data, out_vc); end
      recv_port_id = 2'd0;
   endtask

   task automatic test_reset_mid_packet;
      do_reset;
      recv_port_id = 2'd0;
      for (int i = 0; i < 4; i++) begin
         flit_in = mk(1'b0, 2'd0, 1'b0, 32'(32'hD1 + i));
         step;
      end
      flit_in = '0;
      out_ready = 1'b1;
      step;
      out_ready = 1'b0;
      tests++; if (credit_out !== 2'b10) begin fails++; $display("FAIL rstmid_credit_pre got=%b want=10", credit_out); end
      tests++; if (dut.state !== 1'b1) begin fails++; $display("FAIL rstmid_locked got=%b want=1", dut.state); end
      tests++; if (dut.count[0] !== 3'd3) begin fails++; $display("FAIL rstmid_count_pre got=%0d want=3", dut.count[0]); end
      rst = 1'b1;
      step;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid got=%b want=0", out_valid); end
      tests++; if (credit_out !== 2'b00) begin fails++; $display("FAIL rstmid_credit got=%b want=00", credit_out); end
      tests++; if (dut.state !== 1'b0) begin fails++; $display("FAIL rstmid_state got=%b want=0", dut.state); end
      tests++; if (dut.count[0] !== 3'd0) begin fails++; $display("FAIL rstmid_count got=%0d want=0", dut.count[0]); end
`ifdef NOC_RECV_STATS_EN
      tests++; if (flit_count !== 32'd0) begin fails++; $display("FAIL rstmid_flit_count got=%0d want=0", flit_count); end
`endif
      rst = 1'b0;
      out_ready = 1'b1;
      step;
      tests++; if (out_valid !== 1'b0 || credit_out !== 2'b00) begin fails++; $display("FAIL rstmid_after got=%b/%b want=0/00", out_valid, credit_out); end
      out_ready = 1'b0;
   endtask

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      flit_in = '0;
      out_ready = 1'b0;
      recv_port_id = 2'd0;
      tests = 0;
      fails = 0;
      test_reset;
      test_overflow;
      test_packet_order;
      test_round_robin;
      test_simultaneous;
      test_misroute;
      test_reset_mid_packet;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/noc_flit_receiver.md
NOC_FLIT_RECEIVER -- requirements
Module: noc_flit_receiver

Interface
REQ-001 Parameter NUM_VCS, default 2: number of virtual channels; VC_BITS = max(1, clog2(NUM_VCS)).
REQ-002 Parameter FLIT_DATA_WIDTH, default 32: flit payload width.
REQ-003 Parameter DEST_BITS, default 2: destination field width.
REQ-004 Parameter BUFFER_DEPTH, default 4 (power of two, >=2): per-VC flit buffer entries; equals credits granted to the upstream router.
REQ-005 clk  in  1: sole clock; all logic on rising edge.
REQ-006 rst  in  1: reset, synchronous and active-high.
REQ-007 flit_in  in  FW = 2+DEST_BITS+VC_BITS+FLIT_DATA_WIDTH: {valid, tail, dest, vc, data}, MSB to LSB.
REQ-008 credit_out  out  1+VC_BITS: {valid, vc}; one credit returned to the router.
REQ-009 recv_port_id  in  DEST_BITS: this endpoint's address, static after reset.
REQ-010 out_valid  out  1: a flit is presented to the local consumer.
REQ-011 out_ready  in  1: consumer accepts; a pop occurs when out_valid && out_ready.
REQ-012 out_data / out_vc / out_tail  out  FLIT_DATA_WIDTH / VC_BITS / 1: fields of the presented flit.
REQ-013 overflow_err / misroute_err  out  1 / 1: sticky error flags.

Function
REQ-014 A valid flit_in is written into the FIFO selected by its vc field in the same cycle; it becomes visible to out_* on the next cycle at the earliest.
REQ-015 Each VC FIFO holds BUFFER_DEPTH entries; pointers wrap modulo BUFFER_DEPTH; occupancy counter is clog2(BUFFER_DEPTH+1) bits.
REQ-016 Valid flit to a full VC: flit dropped, occupancy unchanged, overflow_err set.
REQ-017 Valid flit with dest != recv_port_id: flit still stored, misroute_err set.
REQ-018 Valid flit with vc >= NUM_VCS: flit dropped, overflow_err set.
REQ-019 Output selector FSM states IDLE and LOCKED; reset state IDLE.
REQ-020 IDLE: round-robin among non-empty VCs, starting after the last granted VC (VC0 first after reset); the selected head flit drives out_*, combinationally from FIFO state.
REQ-021 IDLE: pop of a non-tail flit -> LOCKED on that VC; pop of a tail flit -> remain IDLE, round-robin pointer advances.
REQ-022 LOCKED: only the locked VC is presented; out_valid low while that VC is empty; pop of its tail flit -> IDLE.
REQ-023 Every pop emits credit_out = {1, popped vc} exactly one cycle later; credit_out valid is 0 in all other cycles.
REQ-024 Simultaneous write and pop on the same VC: both occur; a full FIFO popped in the same cycle accepts the write without overflow.
REQ-025 Write into an empty VC while out_ready is high: no same-cycle bypass; flit presented next cycle.
REQ-026 At most one credit is issued per cycle; credits never exceed BUFFER_DEPTH outstanding per VC.

Reset
REQ-027 While rst is high at a clock edge: all FIFOs empty, pointers 0, FSM IDLE, round-robin pointer VC0, credit_out = 0, out_valid = 0, both error flags 0, statistics counters 0.
REQ-028 Reset asserted mid-packet discards all buffered flits and issues no credit for them; the upstream router is reset with this block.

Configuration
REQ-029 Macro NOC_RECV_STATS_EN defined: additional outputs flit_count (32 bits, increments per pop) and pkt_count (32 bits, increments per tail pop), both wrapping at 2^32.
REQ-030 Macro NOC_RECV_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.

Verification
REQ-031 NUM_VCS=2, DEPTH=4: inject 4 flits on VC0, out_ready=0 -> no credits; 5th flit -> overflow_err=1, occupancy still 4.
REQ-032 Head flit VC0 (data 'hbeef, tail 0), then VC1 single tail flit, then VC0 tail, out_ready=1 -> output order VC0 'hbeef, VC0 tail, VC1; credits VC0, VC0, VC1, each one cycle after its pop.
REQ-033 Both VCs hold single-flit tail packets, out_ready=1 -> pops alternate VC0, VC1, VC0, VC1.
REQ-034 Full VC0, same cycle: pop and write 'h1234 -> no overflow, occupancy stays 4, 'h1234 popped last.
REQ-035 recv_port_id=1, flit with dest=2 -> misroute_err=1, flit delivered normally.
REQ-036 rst asserted with 3 flits buffered in LOCKED -> next cycle out_valid=0, credit_out=0, FSM IDLE; with NOC_RECV_STATS_EN, flit_count=0.
